// File: rtl/pc_gen.sv
// Fetch program-counter generator for an RV32I-style front end.
// Holds the current fetch PC and offers it to instruction memory with a
// valid/ready handshake. The PC advances when a fetch is accepted. Stall
// holds it. Redirects and traps replace it. A misaligned redirect target is
// turned into a trap entry and the offending address is latched for the
// trap handler.
module pc_gen #(
   parameter int                 XLEN         = 32,
   parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]    TRAP_VECTOR  = XLEN'('h100)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_valid_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            misalign_o,
   output logic [XLEN-1:0] badaddr_o
);

   // BOOT spends one cycle with no valid request so that imem sees a clean
   // start after reset. RUN offers pc_o every cycle.
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   // Architectural state
   state_t          r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_misalign;
   logic [XLEN-1:0] r_badaddr;

   // Next-state values produced by the combinational process
   state_t          w_state_next;
   logic [XLEN-1:0] w_pc_next;
   logic            w_misalign_next;
   logic [XLEN-1:0] w_badaddr_next;

   // Decoded control
   logic            w_pc_valid;
   logic            w_target_misaligned;
   logic            w_fetch_accept;
   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_target_aligned;

   // Sequential incrementer. It wraps naturally modulo 2^XLEN.
   assign w_pc_plus4 = r_pc + PC_STEP;

   // Any nonzero low bit in the target is a misaligned fetch for RV32I
   // without the compressed extension.
   assign w_target_misaligned = (redirect_target[1:0] != 2'b00);

   // The low bits are forced to zero on the aligned path, so pc_o[1:0]
   // stays zero by construction and not only because of the check above.
   assign w_target_aligned = {redirect_target[XLEN-1:2], 2'b00};

   // A fetch is consumed only when a request is actually being offered.
   assign w_fetch_accept = w_pc_valid && fetch_ready;

   // State register: synchronous reset dominates every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
         r_badaddr  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_misalign <= w_misalign_next;
         r_badaddr  <= w_badaddr_next;
      end
   end

   // Next-state and PC selection in fixed priority: trap, misaligned redirect,
   // aligned redirect, stall, accepted fetch, then hold
   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_misalign_next = 1'b0;
      w_badaddr_next  = r_badaddr;
      w_pc_valid      = 1'b0;

      case (r_state)
         ST_BOOT: begin
            w_pc_valid   = 1'b0;
            w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_pc_valid   = 1'b1;
            w_state_next = ST_RUN;
         end
         default: begin
            w_pc_valid   = 1'b0;
            w_state_next = ST_BOOT;
         end
      endcase

      if (trap_valid) begin
         // An external trap takes priority over a simultaneous bad redirect.
         // No misalign pulse is raised and badaddr keeps its last value.
         w_pc_next = TRAP_VECTOR;
      end else if (redirect_valid && w_target_misaligned) begin
         w_pc_next       = TRAP_VECTOR;
         w_misalign_next = 1'b1;
         w_badaddr_next  = redirect_target;
      end else if (redirect_valid) begin
         w_pc_next = w_target_aligned;
      end else if (stall) begin
         w_pc_next = r_pc;
      end else if (w_fetch_accept) begin
         w_pc_next = w_pc_plus4;
      end else begin
         w_pc_next = r_pc;
      end
   end

   assign pc_o       = r_pc;
   assign pc_valid_o = w_pc_valid;
   assign pc_plus4_o = w_pc_plus4;
   assign misalign_o = r_misalign;
   assign badaddr_o  = r_badaddr;

endmodule
